// File: rtl/wave_pkg.sv
// Shared types and default widths for the wave analyzer.
package wave_pkg;

  localparam int DEF_DATA_W   = 10;
  localparam int DEF_PERIOD_W = 16;

  typedef enum logic {
    IDLE,
    MEASURE
  } state_t;

  typedef enum logic {
    LOW,
    HIGH
  } level_t;

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for a multi-bit bus sampled from asynchronous pins.
module sync2 #(
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta_reg;
  logic [W-1:0] sync_reg;

  // Two capture stages; the second stage is the clean, clk-domain copy.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_reg <= '0;
      sync_reg <= '0;
    end else begin
      meta_reg <= d;
      sync_reg <= meta_reg;
    end
  end

  assign q = sync_reg;

endmodule

// File: rtl/wave_analyzer.sv
// Period and peak analyzer for an offset-binary waveform.
// Rising crossings of a hysteretic threshold delimit each measured period.
// Optional build macro: WAVE_ANALYZER_OVERRUN_EN adds a sticky overrun flag
// raised whenever a finished result is dropped because the consumer stalled.
module wave_analyzer
  import wave_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int PERIOD_W = DEF_PERIOD_W,
  parameter int MIDSCALE = 512,
  parameter int HYST     = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [DATA_W-1:0]   sample_in,
  output logic                meas_valid,
  input  logic                meas_ready,
  output logic [PERIOD_W-1:0] period,
  output logic [DATA_W-1:0]   peak_max,
  output logic [DATA_W-1:0]   peak_min,
`ifdef WAVE_ANALYZER_OVERRUN_EN
  output logic                overrun,
`endif
  output logic                timeout
);

  localparam logic [DATA_W-1:0]   HI_TH   = DATA_W'(MIDSCALE + HYST);
  localparam logic [DATA_W-1:0]   LO_TH   = DATA_W'(MIDSCALE - HYST);
  localparam logic [PERIOD_W-1:0] CNT_ONE = PERIOD_W'(1);
  localparam logic [PERIOD_W-1:0] CNT_MAX = '1;

  logic [DATA_W-1:0]   s;
  level_t              level_reg;
  state_t              state_reg;
  logic [PERIOD_W-1:0] count_reg;
  logic [DATA_W-1:0]   acc_max_reg;
  logic [DATA_W-1:0]   acc_min_reg;
  logic                above;
  logic                below;
  logic                rise;
  logic                fire;
  logic                publish;

  sync2 #(.W(DATA_W)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (sample_in),
    .q   (s)
  );

  assign above   = (s >= HI_TH);
  assign below   = (s <= LO_TH);
  assign rise    = (level_reg == LOW) && above;
  assign fire    = meas_valid && meas_ready;
  // A result is taken when the output slot is empty or being emptied this cycle.
  assign publish = (state_reg == MEASURE) && rise && (!meas_valid || fire);

  // Hysteretic level tracker: only leaves a level once the far threshold is hit.
  always_ff @(posedge clk) begin
    if (rst) begin
      level_reg <= LOW;
    end else if (level_reg == LOW && above) begin
      level_reg <= HIGH;
    end else if (level_reg == HIGH && below) begin
      level_reg <= LOW;
    end
  end

  // Measurement FSM: period counter, peak accumulators and saturation timeout.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      count_reg   <= '0;
      acc_max_reg <= '0;
      acc_min_reg <= '0;
      timeout     <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (rise) begin
            state_reg   <= MEASURE;
            count_reg   <= CNT_ONE;
            acc_max_reg <= s;
            acc_min_reg <= s;
          end
        end
        MEASURE: begin
          if (rise) begin
            count_reg   <= CNT_ONE;
            acc_max_reg <= s;
            acc_min_reg <= s;
          end else if (count_reg == CNT_MAX - CNT_ONE) begin
            // Counter pins at all-ones: abandon this period without reporting.
            count_reg <= CNT_MAX;
            timeout   <= 1'b1;
            state_reg <= IDLE;
          end else begin
            count_reg   <= count_reg + CNT_ONE;
            acc_max_reg <= (s > acc_max_reg) ? s : acc_max_reg;
            acc_min_reg <= (s < acc_min_reg) ? s : acc_min_reg;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Output slot: load on publish, otherwise empty it when the consumer accepts.
  always_ff @(posedge clk) begin
    if (rst) begin
      meas_valid <= 1'b0;
      period     <= '0;
      peak_max   <= '0;
      peak_min   <= '0;
    end else if (publish) begin
      meas_valid <= 1'b1;
      period     <= count_reg;
      peak_max   <= acc_max_reg;
      peak_min   <= acc_min_reg;
    end else if (fire) begin
      meas_valid <= 1'b0;
    end
  end

`ifdef WAVE_ANALYZER_OVERRUN_EN
  logic drop;
  assign drop = (state_reg == MEASURE) && rise && meas_valid && !meas_ready;

  // Sticky record that a finished result was lost to a stalled consumer.
  always_ff @(posedge clk) begin
    if (rst) begin
      overrun <= 1'b0;
    end else if (drop) begin
      overrun <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_wave_analyzer.sv
// Directed testbench for wave_analyzer (default parameters).
module tb_wave_analyzer;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  sample_in;
  logic        meas_valid;
  logic        meas_ready;
  logic [15:0] period;
  logic [9:0]  peak_max;
  logic [9:0]  peak_min;
  logic        timeout;
`ifdef WAVE_ANALYZER_OVERRUN_EN
  logic        overrun;
`endif

  int tests = 0;
  int fails = 0;
  int reports = 0;
  int sine_tab [512];

  wave_analyzer dut (
    .clk        (clk),
    .rst        (rst),
    .sample_in  (sample_in),
    .meas_valid (meas_valid),
    .meas_ready (meas_ready),
    .period     (period),
    .peak_max   (peak_max),
    .peak_min   (peak_min),
`ifdef WAVE_ANALYZER_OVERRUN_EN
    .overrun    (overrun),
`endif
    .timeout    (timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step(input int v);
    sample_in = 10'(v);
    tick();
  endtask

  // Hold one level for n cycles; every cycle a result is presented, check it.
  task automatic run_level(input int v, input int n, input int ep, input int emax, input int emin);
    for (int i = 0; i < n; i++) begin
      step(v);
      if (meas_valid) begin
        reports++;
        chk("period", 32'(period), 32'(ep));
        chk("peak_max", 32'(peak_max), 32'(emax));
        chk("peak_min", 32'(peak_min), 32'(emin));
      end
    end
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_valid"}, 32'(meas_valid), 0);
    chk({tag, "_period"}, 32'(period), 0);
    chk({tag, "_max"}, 32'(peak_max), 0);
    chk({tag, "_min"}, 32'(peak_min), 0);
    chk({tag, "_timeout"}, 32'(timeout), 0);
  endtask

  initial begin
    for (int i = 0; i < 512; i++)
      sine_tab[i] = $rtoi(511.5 + 511.5 * $sin(2.0 * 3.14159265358979 * i / 512.0) + 0.5);

    // Reset state
    rst = 1'b1;
    meas_ready = 1'b1;
    sample_in = 10'd0;
    tick();
    tick();
    chk_zero("reset");
`ifdef WAVE_ANALYZER_OVERRUN_EN
    chk("reset_overrun", 32'(overrun), 0);
`endif
    rst = 1'b0;

    // Square 600/400, 100 cycles per level: 5 crossings -> 4 reports
    reports = 0;
    for (int p = 0; p < 5; p++) begin
      run_level(400, 100, 200, 600, 400);
      run_level(600, 100, 200, 600, 400);
    end
    chk("square_reports", 32'(reports), 4);

    // Reset mid-period: everything cleared, next report needs two new crossings
    run_level(400, 50, 200, 600, 400);
    pulse_rst();
    chk_zero("midrst");
    reports = 0;
    run_level(400, 100, 200, 600, 400);
    run_level(600, 100, 200, 600, 400);
    run_level(400, 100, 200, 600, 400);
    chk("midrst_no_early", 32'(reports), 0);
    run_level(600, 100, 200, 600, 400);
    chk("midrst_first", 32'(reports), 1);

    // Full-scale sine, 512 samples per period
    sample_in = 10'(sine_tab[0]);
    pulse_rst();
    reports = 0;
    for (int i = 0; i < 2048; i++) begin
      step(sine_tab[i % 512]);
      if (meas_valid) begin
        reports++;
        chk("sine_period", 32'(period), 512);
        chk("sine_max", 32'(peak_max), 1023);
        chk("sine_min", 32'(peak_min), 0);
      end
    end
    chk("sine_reports", 32'(reports), 3);

    // Stalled consumer: first result held stable, later results dropped
    meas_ready = 1'b0;
    sample_in = 10'd400;
    pulse_rst();
    run_level(400, 100, 200, 600, 400);
    run_level(600, 100, 200, 600, 400);
    run_level(400, 100, 200, 600, 400);
    run_level(610, 100, 200, 600, 400);
    run_level(400, 100, 200, 600, 400);
    run_level(620, 100, 200, 600, 400);
    run_level(400, 100, 200, 600, 400);
    run_level(630, 100, 200, 600, 400);
    run_level(400, 100, 200, 600, 400);
    chk("stall_valid", 32'(meas_valid), 1);
    chk("stall_period", 32'(period), 200);
    chk("stall_max", 32'(peak_max), 600);
`ifdef WAVE_ANALYZER_OVERRUN_EN
    chk("stall_overrun", 32'(overrun), 1);
`endif

    // Accept in the same cycle a new crossing latches: new result, valid stays
    sample_in = 10'd640;
    tick();
    tick();
    meas_ready = 1'b1;
    tick();
    chk("same_cycle_valid", 32'(meas_valid), 1);
    chk("same_cycle_period", 32'(period), 200);
    chk("same_cycle_max", 32'(peak_max), 630);
    chk("same_cycle_min", 32'(peak_min), 400);
    tick();
    chk("same_cycle_drain", 32'(meas_valid), 0);

    // One crossing then samples inside the hysteresis band: timeout, back to IDLE
    sample_in = 10'd400;
    pulse_rst();
    reports = 0;
    run_level(400, 20, 0, 0, 0);
    step(600);
    for (int i = 0; i < 65540; i++) begin
      step((i % 2 == 1) ? 510 : 515);
      if (meas_valid) reports++;
      if (i == 65529) chk("timeout_early", 32'(timeout), 0);
    end
    chk("timeout_set", 32'(timeout), 1);
    chk("timeout_no_report", 32'(reports), 0);
    run_level(400, 50, 0, 0, 0);
    run_level(600, 50, 0, 0, 0);
    chk("timeout_idle", 32'(reports), 0);
    chk("timeout_sticky", 32'(timeout), 1);
    pulse_rst();
    chk("timeout_cleared", 32'(timeout), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
